// File: rtl/slip_packet_receiver_pkg.sv
// rtl/slip_packet_receiver_pkg.sv - packet_t, SLIP constants and receiver enums shared by the receiver slice
package slip_packet_receiver_pkg;

    localparam int PKT_SIZE_BYTES = 4;
    localparam int PKT_SIZE       = PKT_SIZE_BYTES * 8;
    localparam int COORD_W        = 4;

    // Destination coordinates occupy the first bytes on the wire, i.e. the MSBs.
    typedef struct packed {
        logic [COORD_W-1:0]            x_dest;
        logic [COORD_W-1:0]            y_dest;
        logic [PKT_SIZE-2*COORD_W-1:0] payload;
    } packet_t;

    localparam logic [7:0] SLIP_FLAG = 8'h7E;
    localparam logic [7:0] SLIP_ESC  = 8'h7D;
    localparam logic [7:0] SLIP_XOR  = 8'h20;

    typedef enum logic [2:0] {
        SLIP_ERR_SHORT    = 3'd0,
        SLIP_ERR_NO_END   = 3'd1,
        SLIP_ERR_BAD_ESC  = 3'd2,
        SLIP_ERR_OVERFLOW = 3'd3,
        SLIP_ERR_CHECKSUM = 3'd4
    } slip_rx_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_ESCAPE,
        ST_CHECK_END
    } slip_rx_state_e;

endpackage

// File: rtl/slip_packet_receiver_if.sv
// rtl/slip_packet_receiver_if.sv - byte input, packet output and error/status bundle of the SLIP receiver
interface slip_packet_receiver_if;
    import slip_packet_receiver_pkg::*;

    logic [7:0] in_byte;
    logic       in_valid;
    packet_t    pkt;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       err_valid;
    logic [2:0] err_code;
    logic [7:0] overflow_cnt;

    modport master (
        output in_byte, in_valid, pkt_ready,
        input  pkt, pkt_valid, err_valid, err_code, overflow_cnt
    );

    modport slave (
        input  in_byte, in_valid, pkt_ready,
        output pkt, pkt_valid, err_valid, err_code, overflow_cnt
    );

endinterface

// File: rtl/slip_packet_receiver_pkt_fifo.sv
// rtl/slip_packet_receiver_pkt_fifo.sv - synchronous packet_t FIFO with full/empty flags
module pkt_fifo
    import slip_packet_receiver_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  packet_t push_data,
    input  logic    pop,
    output packet_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    packet_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/slip_packet_receiver.sv
// rtl/slip_packet_receiver.sv - SLIP deframer into packet_t with error reporting and output FIFO; option SLIP_RX_CHECKSUM_EN
module slip_packet_receiver
    import slip_packet_receiver_pkg::*;
#(
    parameter int         PKT_BYTES  = PKT_SIZE_BYTES,
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] FLAG_BYTE  = SLIP_FLAG,
    parameter logic [7:0] ESC_BYTE   = SLIP_ESC,
    parameter logic [7:0] ESC_XOR    = SLIP_XOR
) (
    input  logic                  clk,
    input  logic                  rst,
    slip_packet_receiver_if.slave bus
);

    localparam int CW = $clog2(PKT_BYTES + 2);
    localparam int PW = PKT_BYTES * 8;
`ifdef SLIP_RX_CHECKSUM_EN
    localparam int FRAME_BYTES = PKT_BYTES + 1;
`else
    localparam int FRAME_BYTES = PKT_BYTES;
`endif
    localparam logic [CW-1:0] DATA_LEN  = CW'(PKT_BYTES);
    localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_BYTES);

    slip_rx_state_e state, state_n;
    logic [CW-1:0]  count, count_n;
    logic [PW-1:0]  shreg, shreg_n;
    logic           err_valid_q, err_n;
    logic [2:0]     err_code_q, code_n;
    logic [7:0]     ovf_cnt;
    logic           take, restart, push_req, drop, csum_ok;
    logic [7:0]     take_byte;
    logic           fifo_full, fifo_empty;
    packet_t        fifo_out;

`ifdef SLIP_RX_CHECKSUM_EN
    logic [7:0] sum, sum_n;
    // Data plus a correct checksum byte always totals zero modulo 256.
    assign csum_ok = (sum == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            shreg       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            ovf_cnt     <= '0;
`ifdef SLIP_RX_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            state       <= state_n;
            count       <= count_n;
            shreg       <= shreg_n;
            err_valid_q <= err_n;
            err_code_q  <= code_n;
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
`ifdef SLIP_RX_CHECKSUM_EN
            sum         <= sum_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        shreg_n   = shreg;
        err_n     = 1'b0;
        code_n    = err_code_q;
        take      = 1'b0;
        take_byte = bus.in_byte;
        restart   = 1'b0;
        push_req  = 1'b0;
        drop      = 1'b0;
`ifdef SLIP_RX_CHECKSUM_EN
        sum_n     = sum;
`endif
        if (bus.in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_byte == FLAG_BYTE) begin
                        state_n = ST_RECV;
                        restart = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (bus.in_byte == FLAG_BYTE) begin
                        if (count != '0) begin
                            err_n  = 1'b1;
                            code_n = SLIP_ERR_SHORT;
                        end
                        restart = 1'b1;
                    end else if (bus.in_byte == ESC_BYTE) begin
                        state_n = ST_ESCAPE;
                    end else begin
                        take = 1'b1;
                    end
                end
                ST_ESCAPE: begin
                    if (bus.in_byte == (FLAG_BYTE ^ ESC_XOR) ||
                        bus.in_byte == (ESC_BYTE ^ ESC_XOR)) begin
                        take      = 1'b1;
                        take_byte = bus.in_byte ^ ESC_XOR;
                    end else if (bus.in_byte == FLAG_BYTE) begin
                        err_n   = 1'b1;
                        code_n  = SLIP_ERR_BAD_ESC;
                        state_n = ST_RECV;
                        restart = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = SLIP_ERR_BAD_ESC;
                        state_n = ST_IDLE;
                    end
                end
                ST_CHECK_END: begin
                    if (bus.in_byte == FLAG_BYTE) begin
                        state_n = ST_RECV;
                        restart = 1'b1;
                        if (csum_ok) begin
                            push_req = 1'b1;
                        end else begin
                            err_n  = 1'b1;
                            code_n = SLIP_ERR_CHECKSUM;
                        end
                    end else begin
                        err_n   = 1'b1;
                        code_n  = SLIP_ERR_NO_END;
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (take) begin
            // The checksum byte advances the count but never enters the packet.
            if (count < DATA_LEN) shreg_n = {shreg[PW-9:0], take_byte};
            count_n = count + 1'b1;
            state_n = (count_n == FRAME_LEN) ? ST_CHECK_END : ST_RECV;
`ifdef SLIP_RX_CHECKSUM_EN
            sum_n   = sum + take_byte;
`endif
        end

        if (restart) begin
            count_n = '0;
`ifdef SLIP_RX_CHECKSUM_EN
            sum_n   = '0;
`endif
        end

        if (push_req && fifo_full && !bus.pkt_ready) begin
            drop   = 1'b1;
            err_n  = 1'b1;
            code_n = SLIP_ERR_OVERFLOW;
        end
    end

    pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (packet_t'(shreg)),
        .pop       (bus.pkt_ready),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.pkt          = fifo_out;
    assign bus.pkt_valid    = !fifo_empty;
    assign bus.err_valid    = err_valid_q;
    assign bus.err_code     = err_code_q;
    assign bus.overflow_cnt = ovf_cnt;

endmodule

// File: tb/tb_slip_packet_receiver.sv
// tb/tb_slip_packet_receiver.sv - randomized self-checking bench for slip_packet_receiver
module tb_slip_packet_receiver;
    import slip_packet_receiver_pkg::*;

    localparam int PB = PKT_SIZE_BYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slip_packet_receiver_if bus();

    slip_packet_receiver #(.PKT_BYTES(PB), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]          stream [$];
    logic [PKT_SIZE-1:0] pkt_q [$];
    logic [PKT_SIZE-1:0] exp_q [$];
    logic [2:0]          err_q [$];
    logic [2:0]          exp_err [$];
    int                  exp_ovf = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err_valid) err_q.push_back(bus.err_code);
            if (bus.pkt_valid && bus.pkt_ready) pkt_q.push_back(bus.pkt);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            bus.in_byte = 8'($urandom);
            cycle();
        end
    endtask

    task automatic send_stream(input int max_gap);
        while (stream.size() > 0) send_byte(stream.pop_front(), max_gap);
    endtask

    task automatic add_enc(input logic [7:0] b);
        if (b == 8'h7E) begin
            stream.push_back(8'h7D); stream.push_back(8'h5E);
        end else if (b == 8'h7D) begin
            stream.push_back(8'h7D); stream.push_back(8'h5D);
        end else begin
            stream.push_back(b);
        end
    endtask

    // Encoded data bytes (first byte = packet MSBs) plus checksum when enabled, no flags.
    task automatic add_body(input logic [PKT_SIZE-1:0] v);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        for (int i = 0; i < PB; i++) begin
            b = v[PKT_SIZE-1-8*i -: 8];
            s = s + b;
            add_enc(b);
        end
`ifdef SLIP_RX_CHECKSUM_EN
        add_enc(8'h00 - s);
`endif
    endtask

    task automatic add_frame(input logic [PKT_SIZE-1:0] v);
        stream.push_back(8'h7E);
        add_body(v);
        stream.push_back(8'h7E);
    endtask

    function automatic logic [PKT_SIZE-1:0] rand_pkt();
        logic [PKT_SIZE-1:0] v;
        for (int i = 0; i < PB; i++) begin
            case ($urandom_range(3, 0))
                0:       v[8*i +: 8] = 8'h7E;
                1:       v[8*i +: 8] = 8'h7D;
                default: v[8*i +: 8] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic clear_all();
        pkt_q.delete(); exp_q.delete(); err_q.delete(); exp_err.delete();
    endtask

    task automatic test_reset();
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got %0b want 0", bus.pkt_valid); end
        checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %0b want 0", bus.err_valid); end
        checks++; if (bus.err_code !== 3'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", bus.err_code); end
        checks++; if (bus.overflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_overflow_cnt got %0d want 0", bus.overflow_cnt); end
        checks++; if (bus.pkt !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", bus.pkt); end
    endtask

    task automatic test_basic();
        clear_all();
        bus.pkt_ready = 1'b1;
        add_frame(32'h12345678);
        send_stream(0);
        checks++; if (bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_latency pkt_valid got %0b want 1", bus.pkt_valid); end
        checks++; if (bus.pkt !== 32'h12345678) begin errors++; $display("FAIL basic_pkt got %h want 12345678", bus.pkt); end
        checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL basic_err_valid got %0b want 0", bus.err_valid); end
        repeat (3) cycle();
        checks++; if (pkt_q.size() != 1 || err_q.size() != 0) begin errors++; $display("FAIL basic_counts got %0d pkts %0d errs want 1 0", pkt_q.size(), err_q.size()); end
    endtask

    task automatic test_escape();
        clear_all();
        bus.pkt_ready = 1'b1;
        add_frame(32'h7E7D0001);
        send_stream(0);
        add_frame(32'h7E7D0001);
        send_stream(3);
        repeat (3) cycle();
        checks++; if (pkt_q.size() != 2 || err_q.size() != 0) begin errors++; $display("FAIL escape_counts got %0d pkts %0d errs want 2 0", pkt_q.size(), err_q.size()); end
        for (int i = 0; i < pkt_q.size(); i++) begin
            checks++; if (pkt_q[i] !== 32'h7E7D0001) begin errors++; $display("FAIL escape_pkt[%0d] got %h want 7e7d0001", i, pkt_q[i]); end
        end
    endtask

    task automatic test_short();
        clear_all();
        bus.pkt_ready = 1'b1;
        stream.push_back(8'h7E); stream.push_back(8'h11); stream.push_back(8'h22);
        stream.push_back(8'h7E);
        add_frame(32'hAABBCCDD);
        send_stream(1);
        repeat (3) cycle();
        checks++; if (err_q.size() != 1) begin errors++; $display("FAIL short_err_count got %0d want 1", err_q.size()); end
        else begin checks++; if (err_q[0] !== 3'd0) begin errors++; $display("FAIL short_err_code got %0d want 0", err_q[0]); end end
        checks++; if (pkt_q.size() != 1) begin errors++; $display("FAIL short_pkt_count got %0d want 1", pkt_q.size()); end
        else begin checks++; if (pkt_q[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL short_pkt got %h want aabbccdd", pkt_q[0]); end end
    endtask

    task automatic test_bad_frames();
        clear_all();
        bus.pkt_ready = 1'b1;
        stream.push_back(8'h7E); add_body(32'hAABBCCDD); stream.push_back(8'h55);
        exp_err.push_back(3'd1);
        stream.push_back(8'h7E); stream.push_back(8'h7D); stream.push_back(8'h41);
        exp_err.push_back(3'd2);
        // Must be ignored in IDLE; a deframer stuck in RECV would push these.
        stream.push_back(8'hAA); stream.push_back(8'hBB); stream.push_back(8'hCC); stream.push_back(8'hDD);
        stream.push_back(8'h7E);
        stream.push_back(8'h12); stream.push_back(8'h7D); stream.push_back(8'h7E);
        exp_err.push_back(3'd2);
        add_body(32'h11223344); stream.push_back(8'h7E);
        exp_q.push_back(32'h11223344);
        send_stream(2);
        repeat (3) cycle();
        checks++; if (err_q.size() != exp_err.size()) begin errors++; $display("FAIL bad_err_count got %0d want %0d", err_q.size(), exp_err.size()); end
        for (int i = 0; i < err_q.size() && i < exp_err.size(); i++) begin
            checks++; if (err_q[i] !== exp_err[i]) begin errors++; $display("FAIL bad_err_code[%0d] got %0d want %0d", i, err_q[i], exp_err[i]); end
        end
        checks++; if (pkt_q.size() != 1) begin errors++; $display("FAIL bad_pkt_count got %0d want 1", pkt_q.size()); end
        else begin checks++; if (pkt_q[0] !== exp_q[0]) begin errors++; $display("FAIL bad_pkt got %h want %h", pkt_q[0], exp_q[0]); end end
    endtask

    task automatic test_overflow();
        clear_all();
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rand_pkt());
            add_frame(exp_q[i]);
        end
        send_stream(1);
        repeat (3) cycle();
        exp_ovf++;
        checks++; if (bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL ovf_pkt_valid got %0b want 1", bus.pkt_valid); end
        checks++; if (bus.pkt !== exp_q[0]) begin errors++; $display("FAIL ovf_head_held got %h want %h", bus.pkt, exp_q[0]); end
        checks++; if (bus.overflow_cnt !== 8'(exp_ovf)) begin errors++; $display("FAIL ovf_cnt got %0d want %0d", bus.overflow_cnt, exp_ovf); end
        checks++; if (err_q.size() != 1) begin errors++; $display("FAIL ovf_err_count got %0d want 1", err_q.size()); end
        else begin checks++; if (err_q[0] !== 3'd3) begin errors++; $display("FAIL ovf_err_code got %0d want 3", err_q[0]); end end
        bus.pkt_ready = 1'b1;
        repeat (4) cycle();
        checks++; if (pkt_q.size() != 2) begin errors++; $display("FAIL ovf_drain_count got %0d want 2", pkt_q.size()); end
        for (int i = 0; i < pkt_q.size() && i < 2; i++) begin
            checks++; if (pkt_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", i, pkt_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] last;
        clear_all();
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rand_pkt());
            add_frame(exp_q[i]);
        end
        last = stream.pop_back();
        send_stream(1);
        // The closing flag of the third frame coincides with a pop of the full FIFO.
        bus.pkt_ready = 1'b1;
        send_byte(last, 0);
        repeat (5) cycle();
        checks++; if (err_q.size() != 0) begin errors++; $display("FAIL fullpop_err_count got %0d want 0", err_q.size()); end
        checks++; if (bus.overflow_cnt !== 8'(exp_ovf)) begin errors++; $display("FAIL fullpop_ovf got %0d want %0d", bus.overflow_cnt, exp_ovf); end
        checks++; if (pkt_q.size() != 3) begin errors++; $display("FAIL fullpop_count got %0d want 3", pkt_q.size()); end
        for (int i = 0; i < pkt_q.size() && i < 3; i++) begin
            checks++; if (pkt_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_pkt[%0d] got %h want %h", i, pkt_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int k;
        clear_all();
        bus.pkt_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(4, 0) == 0) begin
                k = $urandom_range(PB - 1, 1);
                stream.push_back(8'h7E);
                for (int j = 0; j < k; j++) stream.push_back(8'($urandom_range(8'h70, 8'h00)));
                exp_err.push_back(3'd0);
            end
            if ($urandom_range(1, 0) == 1) stream.push_back(8'h7E);
            exp_q.push_back(rand_pkt());
            add_frame(exp_q[exp_q.size() - 1]);
            send_stream(2);
        end
        repeat (4) cycle();
        checks++; if (pkt_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_pkt_count got %0d want %0d", pkt_q.size(), exp_q.size()); end
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) begin
            checks++; if (pkt_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pkt[%0d] got %h want %h", i, pkt_q[i], exp_q[i]); end
        end
        checks++; if (err_q.size() != exp_err.size()) begin errors++; $display("FAIL rand_err_count got %0d want %0d", err_q.size(), exp_err.size()); end
        for (int i = 0; i < err_q.size() && i < exp_err.size(); i++) begin
            checks++; if (err_q[i] !== exp_err[i]) begin errors++; $display("FAIL rand_err[%0d] got %0d want %0d", i, err_q[i], exp_err[i]); end
        end
    endtask

    task automatic test_saturation();
        int n_drop;
        int n_three;
        clear_all();
        bus.pkt_ready = 1'b0;
        n_drop = 300;
        for (int i = 0; i < 2 + n_drop; i++) begin
            add_frame(32'h0102_0304 + i);
            send_stream(0);
        end
        repeat (2) cycle();
        exp_ovf = (exp_ovf + n_drop > 255) ? 255 : exp_ovf + n_drop;
        n_three = 0;
        foreach (err_q[i]) if (err_q[i] == 3'd3) n_three++;
        checks++; if (bus.overflow_cnt !== 8'(exp_ovf)) begin errors++; $display("FAIL sat_ovf got %0d want %0d", bus.overflow_cnt, exp_ovf); end
        checks++; if (n_three != n_drop || err_q.size() != n_drop) begin errors++; $display("FAIL sat_err_count got %0d/%0d want %0d", n_three, err_q.size(), n_drop); end
        bus.pkt_ready = 1'b1;
        repeat (4) cycle();
        checks++; if (pkt_q.size() != 2) begin errors++; $display("FAIL sat_drain got %0d want 2", pkt_q.size()); end
        else begin
            checks++; if (pkt_q[1] !== 32'h0102_0305) begin errors++; $display("FAIL sat_second got %h want 01020305", pkt_q[1]); end
        end
    endtask

`ifdef SLIP_RX_CHECKSUM_EN
    task automatic test_checksum();
        clear_all();
        bus.pkt_ready = 1'b1;
        stream = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6, 8'h7E};
        send_stream(0);
        stream = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5, 8'h7E};
        send_stream(1);
        repeat (3) cycle();
        checks++; if (pkt_q.size() != 1) begin errors++; $display("FAIL csum_pkt_count got %0d want 1", pkt_q.size()); end
        else begin checks++; if (pkt_q[0] !== 32'h01020304) begin errors++; $display("FAIL csum_pkt got %h want 01020304", pkt_q[0]); end end
        checks++; if (err_q.size() != 1) begin errors++; $display("FAIL csum_err_count got %0d want 1", err_q.size()); end
        else begin checks++; if (err_q[0] !== 3'd4) begin errors++; $display("FAIL csum_err_code got %0d want 4", err_q[0]); end end
    endtask
`endif

    initial begin
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.pkt_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        cycle();
        test_basic();
        test_escape();
        test_short();
        test_bad_frames();
        test_overflow();
        test_full_pop();
        test_random();
`ifdef SLIP_RX_CHECKSUM_EN
        test_checksum();
`endif
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
